// File: rtl/sprite_fetcher.sv
// Sprite tile-row fetcher: pulls matching sprites off the sprite chain, reads both
// bitplanes from VRAM and overlays the decoded row onto an 8-entry pixel FIFO.
module sprite_fetcher (
   input  logic        clk,
   input  logic        rst,
   input  logic        drawing,
   input  logic        line_start,
   input  logic        cfg_tall_sprites,
   input  logic        shift_en,
   input  logic [3:0]  sp_dy,
   input  logic [7:0]  sp_tile,
   input  logic [3:0]  sp_attrs,
   input  logic        sp_valid,
   output logic        query,
   output logic        stall,
   output logic [12:0] vram_addr,
   output logic        vram_rd,
   input  logic [7:0]  vram_d_in,
   output logic [1:0]  px_color,
   output logic        px_palette,
   output logic        px_priority
);

   typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, MERGE} state_t;

   state_t            state;
   logic [7:0]        lo_p1;
   logic              xflip_p0;
   logic              pal_p0;
   logic              pri_p0;
   logic [7:0][1:0]   fifo_col;
   logic [7:0]        fifo_pal;
   logic [7:0]        fifo_pri;
   logic [7:0][1:0]   new_col;
   logic              take;

   // Row within the sprite after yflip; tall sprites pick the odd tile for the lower half.
   function automatic logic [12:0] lo_addr(input logic [3:0] dy, input logic [7:0] tile,
                                           input logic yflip, input logic tall);
      logic [3:0] row;
      logic [7:0] t;
      row = yflip ? ((tall ? 4'd15 : 4'd7) - dy) : dy;
      t   = tall ? {tile[7:1], row[3]} : tile;
      return {1'b0, t, row[2:0], 1'b0};
   endfunction

   function automatic logic [1:0] pix_color(input logic [7:0] lo, input logic [7:0] hi,
                                            input logic xflip, input logic [2:0] i);
      logic [2:0] b;
      b = xflip ? i : (3'd7 - i);
      return {hi[b], lo[b]};
   endfunction

   assign query       = rst & (state == IDLE) & drawing & ~line_start;
   assign take        = sp_valid & query;
   assign stall       = rst & ((state != IDLE) | take);
   assign px_color    = fifo_col[0];
   assign px_palette  = fifo_pal[0];
   assign px_priority = fifo_pri[0];

   always_comb begin
      new_col = '0;
      for (int i = 0; i < 8; i++)
         new_col[i] = pix_color(lo_p1, vram_d_in, xflip_p0, 3'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         fifo_col  <= '0;
         fifo_pal  <= '0;
         fifo_pri  <= '0;
      end else if (line_start) begin
         state     <= IDLE;
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         fifo_col  <= '0;
         fifo_pal  <= '0;
         fifo_pri  <= '0;
      end else begin
         case (state)
            // p0: latch the chain's sprite and issue the low-plane read
            IDLE: begin
               vram_rd   <= 1'b0;
               vram_addr <= '0;
               if (take) begin
                  xflip_p0  <= sp_attrs[1];
                  pal_p0    <= sp_attrs[0];
                  pri_p0    <= sp_attrs[3];
                  vram_rd   <= 1'b1;
                  vram_addr <= lo_addr(sp_dy, sp_tile, sp_attrs[2], cfg_tall_sprites);
                  state     <= FETCH_LO;
               end else if (shift_en) begin
                  for (int i = 0; i < 7; i++) begin
                     fifo_col[i] <= fifo_col[i+1];
                     fifo_pal[i] <= fifo_pal[i+1];
                     fifo_pri[i] <= fifo_pri[i+1];
                  end
                  fifo_col[7] <= 2'd0;
                  fifo_pal[7] <= 1'b0;
                  fifo_pri[7] <= 1'b0;
               end
            end
            FETCH_LO: begin
               vram_rd   <= 1'b1;
               vram_addr <= {vram_addr[12:1], 1'b1};
               state     <= FETCH_HI;
            end
            // p1: low plane arrives
            FETCH_HI: begin
               lo_p1     <= vram_d_in;
               vram_rd   <= 1'b0;
               vram_addr <= '0;
               state     <= MERGE;
            end
            // p2: high plane arrives; only transparent slots take a new opaque pixel
            MERGE: begin
               for (int i = 0; i < 8; i++) begin
                  if (fifo_col[i] == 2'd0 && new_col[i] != 2'd0) begin
                     fifo_col[i] <= new_col[i];
                     fifo_pal[i] <= pal_p0;
                     fifo_pri[i] <= pri_p0;
                  end
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_fetcher.sv
// Directed bench for sprite_fetcher with a behavioural one-cycle-latency VRAM.
module tb_sprite_fetcher;

   logic        clk = 1'b0;
   logic        rst, drawing, line_start, cfg_tall_sprites, shift_en, sp_valid;
   logic [3:0]  sp_dy, sp_attrs;
   logic [7:0]  sp_tile;
   logic        query, stall, vram_rd;
   logic [12:0] vram_addr;
   logic [7:0]  vram_d_in;
   logic [1:0]  px_color;
   logic        px_palette, px_priority;

   always #5 clk = ~clk;

   sprite_fetcher dut (
      .clk(clk), .rst(rst), .drawing(drawing), .line_start(line_start),
      .cfg_tall_sprites(cfg_tall_sprites), .shift_en(shift_en),
      .sp_dy(sp_dy), .sp_tile(sp_tile), .sp_attrs(sp_attrs), .sp_valid(sp_valid),
      .query(query), .stall(stall), .vram_addr(vram_addr), .vram_rd(vram_rd),
      .vram_d_in(vram_d_in), .px_color(px_color), .px_palette(px_palette),
      .px_priority(px_priority)
   );

   logic [7:0] vram [0:8191];
   always @(posedge clk) vram_d_in <= vram_rd ? vram[vram_addr] : 8'h00;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  tile;
      logic [3:0]  dy;
      logic [3:0]  attrs;
      logic        tall;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [12:0] addr;
      logic [15:0] cols;   // {px7,...,px0}
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_line();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   // Presents one sprite on the chain and watches the bus for a fixed window.
   task automatic run_fetch(input logic [7:0] tile, input logic [3:0] dy, input logic [3:0] attrs,
                            output int stalls, output logic [12:0] a0, output logic [12:0] a1,
                            output int nrd);
      sp_tile = tile; sp_dy = dy; sp_attrs = attrs; sp_valid = 1'b1;
      stalls = 0; nrd = 0; a0 = '0; a1 = '0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (stall) stalls++;
         if (vram_rd) begin
            if (nrd == 0) a0 = vram_addr;
            else if (nrd == 1) a1 = vram_addr;
            nrd++;
         end
         step();
         sp_valid = 1'b0;
      end
   endtask

   task automatic check_fifo(input string nm, input logic [15:0] cols,
                             input logic [7:0] pal, input logic [7:0] pri);
      logic [1:0] ec;
      logic       ep, eq;
      for (int i = 0; i < 9; i++) begin
         ec = (i < 8) ? cols[2*i +: 2] : 2'd0;
         ep = (i < 8 && ec != 2'd0) ? pal[i] : 1'b0;
         eq = (i < 8 && ec != 2'd0) ? pri[i] : 1'b0;
         check($sformatf("%s_px%0d", nm, i), 32'({px_color, px_palette, px_priority}),
               32'({ec, ep, eq}));
         shift_en = 1'b1;
         step();
         shift_en = 1'b0;
      end
   endtask

   initial begin
      int          stalls, nrd;
      logic [12:0] a0, a1;

      vecs[0] = '{8'h12, 4'd3,  4'b0000, 1'b0, 8'hF0, 8'hCC, 13'h126,
                  {2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3}};
      vecs[1] = '{8'h05, 4'd1,  4'b0010, 1'b0, 8'h80, 8'h00, 13'h052,
                  {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
      vecs[2] = '{8'h05, 4'd1,  4'b0000, 1'b0, 8'h80, 8'h00, 13'h052,
                  {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}};
      vecs[3] = '{8'h12, 4'd2,  4'b0100, 1'b1, 8'h01, 8'h80, 13'h13A,
                  {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
      vecs[4] = '{8'h12, 4'd12, 4'b0100, 1'b1, 8'hAA, 8'h55, 13'h126,
                  {2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1}};
      vecs[5] = '{8'h03, 4'd2,  4'b1101, 1'b0, 8'h0F, 8'hF0, 13'h03A,
                  {2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2}};

      for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
      rst = 1'b0; drawing = 1'b1; line_start = 1'b0; cfg_tall_sprites = 1'b0;
      shift_en = 1'b0; sp_valid = 1'b0; sp_dy = '0; sp_tile = '0; sp_attrs = '0;
      step(); step();
      check("reset_query", 32'(query), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      check("reset_vram", 32'({vram_rd, vram_addr}), 32'd0);
      check("reset_px", 32'({px_color, px_palette, px_priority}), 32'd0);
      rst = 1'b1;
      step();

      for (int v = 0; v < 6; v++) begin
         vram[vecs[v].addr]     = vecs[v].lo;
         vram[vecs[v].addr + 1] = vecs[v].hi;
         cfg_tall_sprites = vecs[v].tall;
         new_line();
         run_fetch(vecs[v].tile, vecs[v].dy, vecs[v].attrs, stalls, a0, a1, nrd);
         check($sformatf("v%0d_stalls", v), 32'(stalls), 32'd4);
         check($sformatf("v%0d_nreads", v), 32'(nrd), 32'd2);
         check($sformatf("v%0d_addr_lo", v), 32'(a0), 32'(vecs[v].addr));
         check($sformatf("v%0d_addr_hi", v), 32'(a1), 32'(vecs[v].addr + 13'd1));
         check_fifo($sformatf("v%0d", v), vecs[v].cols, {8{vecs[v].attrs[0]}},
                    {8{vecs[v].attrs[3]}});
      end
      cfg_tall_sprites = 1'b0;

      // Two sprites at one x: A (palette 0) then B (palette 1), fetched back to back.
      vram[13'h200] = 8'h0F; vram[13'h201] = 8'h00;
      vram[13'h210] = 8'hFF; vram[13'h211] = 8'hFF;
      new_line();
      stalls = 0;
      for (int c = 0; c < 14; c++) begin
         sp_valid = 1'b0;
         if (c == 0) begin
            sp_tile = 8'h20; sp_dy = 4'd0; sp_attrs = 4'b0000; sp_valid = 1'b1;
         end else if (c == 4) begin
            sp_tile = 8'h21; sp_dy = 4'd0; sp_attrs = 4'b0001; sp_valid = 1'b1;
         end
         #1;
         if (c == 3) check("pair_query_in_merge", 32'(query), 32'd0);
         if (c == 4) check("pair_query_after_merge", 32'(query), 32'd1);
         if (stall) stalls++;
         step();
      end
      sp_valid = 1'b0;
      check("pair_stalls", 32'(stalls), 32'd8);
      check_fifo("pair", {2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3},
                 8'b0000_1111, 8'h00);

      // line_start while FETCH_HI is in flight discards the fetch and clears the FIFO.
      vram[13'h300] = 8'hF0; vram[13'h301] = 8'h00;
      vram[13'h310] = 8'hFF; vram[13'h311] = 8'hFF;
      new_line();
      run_fetch(8'h30, 4'd0, 4'b0000, stalls, a0, a1, nrd);
      check("ls_prefill_px0", 32'(px_color), 32'd1);
      sp_tile = 8'h31; sp_dy = 4'd0; sp_attrs = 4'b0000; sp_valid = 1'b1;
      step();
      sp_valid = 1'b0;
      step();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      #1;
      check("ls_stall", 32'(stall), 32'd0);
      check("ls_query_idle", 32'(query), 32'd1);
      check("ls_vram_rd", 32'(vram_rd), 32'd0);
      step(); step(); step();
      check_fifo("ls", 16'h0000, 8'h00, 8'h00);

      // Reset during FETCH_LO, then a normal fetch afterwards.
      new_line();
      run_fetch(8'h30, 4'd0, 4'b1001, stalls, a0, a1, nrd);
      check("rst_prefill_px0", 32'({px_color, px_palette, px_priority}), 32'b1_1_1);
      sp_tile = 8'h31; sp_dy = 4'd0; sp_attrs = 4'b0000; sp_valid = 1'b1;
      step();
      sp_valid = 1'b0;
      check("rst_in_fetch_lo", 32'(vram_rd), 32'd1);
      rst = 1'b0;
      step();
      check("rst_query", 32'(query), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_vram", 32'({vram_rd, vram_addr}), 32'd0);
      check("rst_px", 32'({px_color, px_palette, px_priority}), 32'd0);
      rst = 1'b1;
      step();
      vram[vecs[0].addr] = vecs[0].lo; vram[vecs[0].addr + 1] = vecs[0].hi;
      run_fetch(vecs[0].tile, vecs[0].dy, vecs[0].attrs, stalls, a0, a1, nrd);
      check("post_rst_stalls", 32'(stalls), 32'd4);
      check("post_rst_addr", 32'({a0, a1}), 32'({13'h126, 13'h127}));
      check_fifo("post_rst", vecs[0].cols, 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
